// File: rtl/tdd_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tdd_frame_sequencer
//  Description : Time-division-duplex frame engine. After a sync event it
//                waits a startup delay, then runs a programmable number of
//                frames, driving per-channel gated, polarity-controlled
//                on/off windows. Includes a periodic internal sync generator
//                and optional sync-triggered restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdd_frame_sequencer #(
  parameter int CHANNEL_COUNT     = 8,
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int SYNC_COUNT_WIDTH  = 64
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     tdd_enable,
  input  logic                                     tdd_sync_ext,
  input  logic                                     tdd_sync_ext_en,
  input  logic                                     tdd_sync_int_en,
  input  logic                                     tdd_sync_soft,
  input  logic                                     tdd_sync_rst,
  input  logic [BURST_COUNT_WIDTH-1:0]             tdd_burst_count,
  input  logic [REGISTER_WIDTH-1:0]                tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]                tdd_frame_length,
  input  logic [SYNC_COUNT_WIDTH-1:0]              tdd_sync_period,
  input  logic [CHANNEL_COUNT-1:0]                 tdd_channel_en,
  input  logic [CHANNEL_COUNT-1:0]                 tdd_channel_pol,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  tdd_channel_on,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  tdd_channel_off,
  output logic [CHANNEL_COUNT-1:0]                 tdd_channel,
  output logic [1:0]                               tdd_cstate,
  output logic [REGISTER_WIDTH-1:0]                tdd_counter,
  output logic                                     tdd_endof_frame,
  output logic                                     tdd_sync_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_WAITING = 2'b10,
    ST_RUNNING = 2'b11
  } state_t;

  state_t                        state;
  state_t                        start_state;
  logic [REGISTER_WIDTH-1:0]     counter;
  logic [REGISTER_WIDTH-1:0]     delay_l;
  logic [REGISTER_WIDTH-1:0]     delay_last;
  logic [REGISTER_WIDTH-1:0]     flen_l;
  logic [BURST_COUNT_WIDTH-1:0]  burst_l;
  logic [BURST_COUNT_WIDTH-1:0]  frame_cnt;
  logic [BURST_COUNT_WIDTH-1:0]  frame_cnt_inc;
  logic [SYNC_COUNT_WIDTH-1:0]   sync_cnt;
  logic [SYNC_COUNT_WIDTH-1:0]   period_last;
  logic                          sync_gen_run;
  logic                          sync_hit;
  logic                          ext_prev;
  logic                          sync_any;
  logic                          restart;
  logic                          frame_end;
  logic                          burst_done;
  logic                          q_update;
  logic [CHANNEL_COUNT-1:0]      q;
  logic [CHANNEL_COUNT-1:0]      q_next;

  // Internal sync generator decode
  assign sync_gen_run = tdd_enable & tdd_sync_int_en & (tdd_sync_period != '0);
  assign period_last  = tdd_sync_period - SYNC_COUNT_WIDTH'(1);
  assign sync_hit     = sync_gen_run & (sync_cnt == period_last);

  // Any accepted sync source; the external edge is taken against last cycle's sample
  assign sync_any = (tdd_sync_ext_en & tdd_sync_ext & ~ext_prev) | tdd_sync_soft | tdd_sync_out;

  // A sync while the sequence is active only restarts it when tdd_sync_rst is set
  assign restart = tdd_sync_rst & sync_any & ((state == ST_WAITING) | (state == ST_RUNNING));

  assign start_state   = (delay_l != '0) ? ST_WAITING : ST_RUNNING;
  assign delay_last    = delay_l - REGISTER_WIDTH'(1);
  assign frame_end     = (state == ST_RUNNING) & (counter == flen_l);
  assign frame_cnt_inc = frame_cnt + BURST_COUNT_WIDTH'(1);
  assign burst_done    = frame_end & (burst_l != '0) & (frame_cnt_inc == burst_l);

  // Raw channel bits only evolve while the frame keeps running; any exit clears them
  assign q_update = tdd_enable & (state == ST_RUNNING) & ~restart & ~burst_done;

  generate
    for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_chan
      logic [REGISTER_WIDTH-1:0] on_pos;
      logic [REGISTER_WIDTH-1:0] off_pos;
      assign on_pos  = tdd_channel_on[i*REGISTER_WIDTH +: REGISTER_WIDTH];
      assign off_pos = tdd_channel_off[i*REGISTER_WIDTH +: REGISTER_WIDTH];
      // off position has priority over on when both match
      assign q_next[i] = q_update & ((counter == off_pos) ? 1'b0 : ((counter == on_pos) | q[i]));
    end
  endgenerate

  assign tdd_cstate      = state;
  assign tdd_counter     = counter;
  assign tdd_endof_frame = frame_end;

  // Periodic sync generator: free-running modulo counter with a one-cycle pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_cnt     <= '0;
      tdd_sync_out <= 1'b0;
    end else if (sync_gen_run) begin
      sync_cnt     <= sync_hit ? '0 : sync_cnt + SYNC_COUNT_WIDTH'(1);
      tdd_sync_out <= sync_hit;
    end else begin
      sync_cnt     <= '0;
      tdd_sync_out <= 1'b0;
    end
  end

  // Previous-cycle sample of the external sync level for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_prev <= 1'b0;
    end else begin
      ext_prev <= tdd_sync_ext;
    end
  end

  // Raw channel state and gated, polarity-adjusted registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q           <= '0;
      tdd_channel <= '0;
    end else begin
      q           <= q_next;
      tdd_channel <= (q_next & tdd_channel_en) ^ tdd_channel_pol;
    end
  end

  // Sequencer state machine with delay/frame counter and burst frame count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      counter   <= '0;
      frame_cnt <= '0;
      burst_l   <= '0;
      delay_l   <= '0;
      flen_l    <= '0;
    end else if (!tdd_enable) begin
      state     <= ST_IDLE;
      counter   <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_ARMED;
          counter   <= '0;
          frame_cnt <= '0;
          burst_l   <= tdd_burst_count;
          delay_l   <= tdd_startup_delay;
          flen_l    <= tdd_frame_length;
        end
        ST_ARMED: begin
          if (sync_any) begin
            state     <= start_state;
            counter   <= '0;
            frame_cnt <= '0;
          end
        end
        ST_WAITING: begin
          if (restart) begin
            state     <= start_state;
            counter   <= '0;
            frame_cnt <= '0;
          end else if (counter == delay_last) begin
            state   <= ST_RUNNING;
            counter <= '0;
          end else begin
            counter <= counter + REGISTER_WIDTH'(1);
          end
        end
        ST_RUNNING: begin
          if (restart) begin
            state     <= start_state;
            counter   <= '0;
            frame_cnt <= '0;
          end else if (frame_end) begin
            counter <= '0;
            if (burst_done) begin
              state     <= ST_ARMED;
              frame_cnt <= '0;
              burst_l   <= tdd_burst_count;
              delay_l   <= tdd_startup_delay;
              flen_l    <= tdd_frame_length;
            end else begin
              frame_cnt <= frame_cnt_inc;
            end
          end else begin
            counter <= counter + REGISTER_WIDTH'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
